fx3_burst_writer: RTL and testbench

Parametrised successor to the FX3 write state machine. It drains the read side of the ADC sample FIFO into the FX3 GPIF slave interface in watermark-terminated bursts, all in the FX3 clock domain. It adds the following over the previous controller:
- configurable data width and burst handling;
- underrun stall;
- a watermark-lag termination count and a burst-length safety cap;
- a built-in test-pattern source;
- status counters for host diagnostics.

---
 rtl/fx3_burst_writer.sv | 157 +++++++++++++++
 tb/tb_fx3_burst_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_burst_writer.sv
// Drains a show-ahead sample FIFO (or an internal test pattern) into the FX3 GPIF slave in watermark-terminated bursts.
// Latency: a word taken in cycle N is on fx3_databus with fx3_nWrite=0 in cycle N+1; fifoRead is combinational.
// Backpressure: an empty FIFO stalls the burst in place; deasserted runEnable or FX3 not-ready aborts to IDLE.
module fx3_burst_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 12,
  parameter int START_LEVEL = 64,
  parameter int WM_LAG      = 4,
  parameter int BURST_LEN   = 8192,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   runEnable,
  input  logic                   testMode,
  input  logic                   clearFlags,
  input  logic [DATA_WIDTH-1:0]  fifoData,
  input  logic                   fifoEmpty,
  input  logic [LEVEL_WIDTH-1:0] fifoLevel,
  output logic                   fifoRead,
  input  logic                   fx3_nReady,
  input  logic                   fx3_th0Ready,
  input  logic                   fx3_th0Watermark,
  output logic                   fx3_nWrite,
  output logic [DATA_WIDTH-1:0]  fx3_databus,
  output logic                   underrun,
  output logic                   capHit,
  output logic [31:0]            burstCount,
  output logic [2:0]             state
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int LW = $clog2(WM_LAG + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_THREAD = 3'd1,
    S_WAIT_DATA   = 3'd2,
    S_WRITE       = 3'd3,
    S_DRAIN       = 3'd4,
    S_GAP         = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_nwrite;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_pat;
  logic [CW-1:0]         r_word_cnt;
  logic [LW-1:0]         r_lag;
  logic [GW-1:0]         r_gap;
  logic                  r_underrun;
  logic                  r_cap;
  logic [31:0]           r_bc;

  logic                  w_active;
  logic                  w_xfer;
  logic                  w_take;
  logic                  w_stall;
  logic                  w_level_ok;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_cap;
  logic                  w_burst_end;
  logic [DATA_WIDTH-1:0] w_word;

  // Word-transfer decode: which source feeds the bus and whether a word moves this cycle
  always_comb begin
    w_active    = runEnable && !fx3_nReady;
    w_xfer      = w_active && ((r_state == S_WRITE) || (r_state == S_DRAIN));
    w_take      = w_xfer && (testMode || !fifoEmpty);
    w_stall     = w_xfer && !testMode && fifoEmpty;
    w_level_ok  = (32'(fifoLevel) >= 32'(START_LEVEL));
    w_cnt_nxt   = r_word_cnt + CW'(1);
    w_cap       = w_take && (w_cnt_nxt == CW'(BURST_LEN));
    w_burst_end = w_cap || ((r_state == S_DRAIN) && w_take && (r_lag == LW'(1)));
    w_word      = testMode ? r_pat : fifoData;
    fifoRead    = w_xfer && !testMode && !fifoEmpty;
  end

  // Burst state machine with registered bus outputs, counters and sticky status
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_IDLE;
      r_nwrite   <= 1'b1;
      r_data     <= '0;
      r_pat      <= '0;
      r_word_cnt <= '0;
      r_lag      <= '0;
      r_gap      <= '0;
      r_underrun <= 1'b0;
      r_cap      <= 1'b0;
      r_bc       <= '0;
    end else begin
      r_nwrite <= !w_take;
      if (w_take) begin
        r_data     <= w_word;
        r_pat      <= r_pat + DATA_WIDTH'(1);
        r_word_cnt <= w_cnt_nxt;
      end
      if (w_stall) begin
        r_underrun <= 1'b1;
      end

      if (!w_active) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT_THREAD;
          S_WAIT_THREAD: begin
            if (!fx3_th0Ready) r_state <= S_WAIT_DATA;
          end
          S_WAIT_DATA: begin
            if (w_level_ok || testMode) begin
              r_state    <= S_WRITE;
              r_pat      <= '0;
              r_word_cnt <= '0;
            end
          end
          S_WRITE, S_DRAIN: begin
            // Cap outranks both the watermark and an in-progress drain
            if (w_burst_end) begin
              r_state <= S_GAP;
              r_gap   <= GW'(GAP_CYCLES - 1);
              r_bc    <= r_bc + 32'd1;
              if (w_cap) r_cap <= 1'b1;
            end else if (w_take && (r_state == S_WRITE) && !fx3_th0Watermark) begin
              r_state <= S_DRAIN;
              r_lag   <= LW'(WM_LAG);
            end else if (w_take && (r_state == S_DRAIN)) begin
              r_lag <= r_lag - LW'(1);
            end
          end
          S_GAP: begin
            if (r_gap == '0) r_state <= S_WAIT_THREAD;
            else             r_gap   <= r_gap - GW'(1);
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // Host clear overrides any set or increment in the same cycle
      if (clearFlags) begin
        r_underrun <= 1'b0;
        r_cap      <= 1'b0;
        r_bc       <= '0;
      end
    end
  end

  assign fx3_nWrite  = r_nwrite;
  assign fx3_databus = r_data;
  assign underrun    = r_underrun;
  assign capHit      = r_cap;
  assign burstCount  = r_bc;
  assign state       = r_state;

endmodule

// File: tb/tb_fx3_burst_writer.sv
// Bench for fx3_burst_writer: FIFO model + scoreboard of expected bus words, monitor pops on every write.
// Latency: words are expected in source order; burst lengths come from watermark timing and the cap.
// Backpressure: FIFO underrun is forced by holding fifoEmpty high for a fixed window.
module tb_fx3_burst_writer;

  logic        clock = 1'b0;
  logic        nReset = 1'b1;
  logic        runEnable = 1'b0;
  logic        testMode = 1'b0;
  logic        clearFlags = 1'b0;
  logic [15:0] fifoData = 16'h0;
  logic        fifoEmpty = 1'b1;
  logic [11:0] fifoLevel = 12'h0;
  logic        fifoRead;
  logic        fx3_nReady = 1'b1;
  logic        fx3_th0Ready = 1'b1;
  logic        fx3_th0Watermark = 1'b1;
  logic        fx3_nWrite;
  logic [15:0] fx3_databus;
  logic        underrun;
  logic        capHit;
  logic [31:0] burstCount;
  logic [2:0]  state;

  fx3_burst_writer dut (
    .clock(clock), .nReset(nReset), .runEnable(runEnable), .testMode(testMode),
    .clearFlags(clearFlags), .fifoData(fifoData), .fifoEmpty(fifoEmpty),
    .fifoLevel(fifoLevel), .fifoRead(fifoRead), .fx3_nReady(fx3_nReady),
    .fx3_th0Ready(fx3_th0Ready), .fx3_th0Watermark(fx3_th0Watermark),
    .fx3_nWrite(fx3_nWrite), .fx3_databus(fx3_databus), .underrun(underrun),
    .capHit(capHit), .burstCount(burstCount), .state(state)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int          taken = 0;
  int          hold_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          cyc = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  logic        drv_rd;
  logic [15:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // Advance n negedges, then step 1 time unit so monitor updates have settled
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic phase_reset();
    wr_cnt = 0; rd_cnt = 0; first_wr = -1; last_wr = -1; taken = 0;
  endtask

  task automatic stop_and_flush();
    runEnable = 1'b0;
    cycles(4);
    exp_q.delete();
    fifo_q.delete();
    cycles(2);
  endtask

  // Show-ahead FIFO model: pops on fifoRead, presents head/empty/level after each edge
  initial begin
    forever begin
      @(negedge clock);
      drv_rd = fifoRead;
      @(posedge clock);
      #1;
      if (drv_rd === 1'b1) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        taken++;
      end
      fifoEmpty = (hold_cnt > 0) || (fifo_q.size() == 0);
      if (hold_cnt > 0) hold_cnt--;
      fifoData  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
      fifoLevel = (fifo_q.size() > 4095) ? 12'd4095 : 12'(fifo_q.size());
    end
  end

  // Monitor: every bus write must match the next expected word
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (fifoRead === 1'b1) rd_cnt++;
      if (fx3_nWrite === 1'b0) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: word 0x%0h written, none expected", fx3_databus);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_data", {48'h0, fx3_databus}, {48'h0, mon_exp});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  t;
    bit  held;
    bit  wm;
    logic [15:0] v;

    // Reset
    #1 nReset = 1'b0;
    cycles(3);
    chk("rst_state", state, 0);
    chk("rst_nwrite", fx3_nWrite, 1);
    chk("rst_databus", fx3_databus, 0);
    chk("rst_fiforead", fifoRead, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_caphit", capHit, 0);
    chk("rst_burstcount", burstCount, 0);
    nReset = 1'b1;
    cycles(2);
    chk("idle_hold", state, 0);

    // Watermark-terminated burst with a 5-cycle underrun in the middle
    for (int i = 0; i < 300; i++) begin
      v = 16'h0100 + 16'(i);
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    fx3_th0Ready = 1'b0;
    cycles(2);
    phase_reset();
    runEnable = 1'b1;
    fx3_nReady = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (fifoRead !== 1'b1 && k < 20);
    #1;
    chk("first_read_latency", k, 3);
    held = 0; wm = 0; t = 0;
    while (burstCount != 32'd1 && t < 400) begin
      cycles(1);
      t++;
      if (taken == 40 && !held) begin hold_cnt = 5; held = 1; end
      if (taken >= 100 && !wm) begin fx3_th0Watermark = 1'b0; wm = 1; end
    end
    if (t >= 400) timeout_fail("wm_burst_end");
    chk("wm_state_gap", state, 5);
    fx3_th0Watermark = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("gap_nwrite", fx3_nWrite, 1);
    end
    stop_and_flush();
    chk("wm_word_count", wr_cnt, 105);
    chk("underrun_idle_cycles", (last_wr - first_wr + 1) - wr_cnt, 5);
    chk("underrun_flag", underrun, 1);
    chk("wm_burstcount", burstCount, 1);
    chk("wm_no_cap", capHit, 0);

    // Clear, then a burst that runs into the length cap
    clearFlags = 1'b1;
    cycles(1);
    clearFlags = 1'b0;
    chk("clr1_underrun", underrun, 0);
    chk("clr1_burstcount", burstCount, 0);
    for (int i = 0; i < 8300; i++) begin
      v = 16'($urandom);
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    cycles(2);
    phase_reset();
    runEnable = 1'b1;
    t = 0;
    while (burstCount != 32'd1 && t < 9000) begin
      cycles(1);
      t++;
    end
    if (t >= 9000) timeout_fail("cap_burst_end");
    chk("cap_state_gap", state, 5);
    chk("cap_flag", capHit, 1);
    stop_and_flush();
    chk("cap_word_count", wr_cnt, 8192);
    chk("cap_no_idle", (last_wr - first_wr + 1) - wr_cnt, 0);
    chk("cap_burstcount", burstCount, 1);

    // Test-pattern source with an empty FIFO
    testMode = 1'b1;
    for (int i = 0; i < 100; i++) exp_q.push_back(16'(i));
    cycles(2);
    phase_reset();
    runEnable = 1'b1;
    wm = 0; t = 0;
    while (burstCount != 32'd2 && t < 200) begin
      cycles(1);
      t++;
      if (wr_cnt >= 20 && !wm) begin fx3_th0Watermark = 1'b0; wm = 1; end
    end
    if (t >= 200) timeout_fail("tp_burst_end");
    fx3_th0Watermark = 1'b1;
    stop_and_flush();
    chk("tp_word_count", wr_cnt, 25);
    chk("tp_no_fiforead", rd_cnt, 0);
    chk("tp_no_idle", (last_wr - first_wr + 1) - wr_cnt, 0);
    chk("tp_burstcount", burstCount, 2);

    // Abort mid-burst by FX3 going not-ready, then clear all status
    for (int i = 0; i < 100; i++) exp_q.push_back(16'(i));
    phase_reset();
    runEnable = 1'b1;
    t = 0;
    while (wr_cnt < 10 && t < 50) begin
      cycles(1);
      t++;
    end
    if (t >= 50) timeout_fail("abort_wait_words");
    fx3_nReady = 1'b1;
    cycles(1);
    chk("abort_state_idle", state, 0);
    chk("abort_nwrite", fx3_nWrite, 1);
    cycles(2);
    chk("abort_word_count", wr_cnt, 10);
    chk("abort_burstcount", burstCount, 2);
    clearFlags = 1'b1;
    cycles(1);
    clearFlags = 1'b0;
    chk("clr2_underrun", underrun, 0);
    chk("clr2_caphit", capHit, 0);
    chk("clr2_burstcount", burstCount, 0);
    runEnable = 1'b0;
    exp_q.delete();
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
